fabric_config_loader: RTL



---
 rtl/fabric_config_loader_if.sv | 24 ++
 rtl/fabric_config_loader.sv | 113 +++++++++++
 2 files changed

// File: rtl/fabric_config_loader_if.sv
// Bus bundle between the config loader, its configuration ROM and the fabric's
// config write decoder: ROM read port plus the valid/ready frame write port.
interface fabric_config_loader_if #(
  parameter int ADDR_W = 6,
  parameter int SEL_W  = 5
);
  logic              rom_rd_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [SEL_W-1:0]  cfg_sel;
  logic [32:0]       cfg_data;

  modport master (
    output rom_rd_en, rom_addr, cfg_valid, cfg_sel, cfg_data,
    input  rom_data, cfg_ready
  );

  modport slave (
    input  rom_rd_en, rom_addr, cfg_valid, cfg_sel, cfg_data,
    output rom_data, cfg_ready
  );
endinterface

// File: rtl/fabric_config_loader.sv
// Walks the configuration ROM two words per target, assembles each 33-bit frame
// and hands it to the fabric config decoder over a valid/ready write port.
module fabric_config_loader #(
  parameter int NUM_TARGETS = 20,
  parameter int BASE_ADDR   = 3,
  parameter int ADDR_W      = 6,
  parameter int SEL_W       = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  fabric_config_loader_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic [SEL_W:0]        frames_loaded
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_LO  = 3'd1,
    CAP_LO = 3'd2,
    CAP_HI = 3'd3,
    PUSH   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [SEL_W-1:0] LAST_INDEX = SEL_W'(NUM_TARGETS - 1);

  state_t           state;
  logic [SEL_W-1:0] index;
  logic [31:0]      lo;

  // ROM word address of a frame's low (hi=0) or high (hi=1) word, wrapping in ADDR_W bits.
  function automatic logic [ADDR_W-1:0] frame_addr(input logic [SEL_W-1:0] idx, input logic hi);
    return ADDR_W'(BASE_ADDR) + ADDR_W'({idx, 1'b0}) + ADDR_W'(hi);
  endfunction

  // Sequencer: ROM strobes and the frame port are registered on state entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      index         <= {SEL_W{1'b0}};
      lo            <= 32'h0000_0000;
      bus.rom_rd_en <= 1'b0;
      bus.rom_addr  <= {ADDR_W{1'b0}};
      bus.cfg_valid <= 1'b0;
      bus.cfg_sel   <= {SEL_W{1'b0}};
      bus.cfg_data  <= 33'h0_0000_0000;
      busy          <= 1'b0;
      done          <= 1'b0;
      frames_loaded <= {(SEL_W+1){1'b0}};
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RD_LO;
            index         <= {SEL_W{1'b0}};
            frames_loaded <= {(SEL_W+1){1'b0}};
            done          <= 1'b0;
            busy          <= 1'b1;
            bus.rom_rd_en <= 1'b1;
            bus.rom_addr  <= frame_addr({SEL_W{1'b0}}, 1'b0);
          end else begin
            state <= state;
          end
        end
        RD_LO: begin
          state         <= CAP_LO;
          bus.rom_rd_en <= 1'b1;
          bus.rom_addr  <= frame_addr(index, 1'b1);
        end
        CAP_LO: begin
          lo            <= bus.rom_data;
          bus.rom_rd_en <= 1'b0;
          state         <= CAP_HI;
        end
        CAP_HI: begin
          // Only bit 0 of the high word belongs to the frame.
          bus.cfg_data  <= {bus.rom_data[0], lo};
          bus.cfg_sel   <= index;
          bus.cfg_valid <= 1'b1;
          state         <= PUSH;
        end
        PUSH: begin
          if (bus.cfg_ready) begin
            bus.cfg_valid <= 1'b0;
            frames_loaded <= frames_loaded + 1'b1;
            if (index == LAST_INDEX) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              index         <= SEL_W'(index + 1'b1);
              state         <= RD_LO;
              bus.rom_rd_en <= 1'b1;
              bus.rom_addr  <= frame_addr(SEL_W'(index + 1'b1), 1'b0);
            end
          end else begin
            state <= PUSH;
          end
        end
        default: begin
          state         <= IDLE;
          bus.rom_rd_en <= 1'b0;
          bus.cfg_valid <= 1'b0;
          busy          <= 1'b0;
          done          <= 1'b0;
        end
      endcase
    end
  end

endmodule
